// File: rtl/calc_pkg.sv
// Shared constants, state encoding and command payload for the scalar-multiply path.
package calc_pkg;

  localparam int unsigned MAX_DIM = 5;
  localparam int unsigned ELEM_W  = 8;
  localparam int unsigned MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int unsigned SCAL_W  = 4;
  localparam int unsigned DIM_W   = 3;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIM_W-1:0]  m;
    logic [DIM_W-1:0]  n;
    logic [SCAL_W-1:0] scalar;
    logic [MAT_W-1:0]  matrix;
  } cmd_t;

  // Bit offset of element (i,j) in a flattened matrix.
  function automatic int unsigned ELEM_IDX(input int unsigned i, input int unsigned j);
    return (i * MAX_DIM + j) * ELEM_W;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; ptr names the requester that wins a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (advance) begin
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

endmodule

// File: rtl/scalar_mul_scheduler.sv
// Shares one combinational scalar-multiply datapath between two requesters,
// returning each result tagged with its requester ID and keeping op/error stats.
module scalar_mul_scheduler
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DIM_W-1:0]  req0_m,
  input  logic [DIM_W-1:0]  req0_n,
  input  logic [SCAL_W-1:0] req0_scalar,
  input  logic [MAT_W-1:0]  req0_matrix,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DIM_W-1:0]  req1_m,
  input  logic [DIM_W-1:0]  req1_n,
  input  logic [SCAL_W-1:0] req1_scalar,
  input  logic [MAT_W-1:0]  req1_matrix,
  output logic              req1_ready,
  output logic [DIM_W-1:0]  mul_m,
  output logic [DIM_W-1:0]  mul_n,
  output logic [SCAL_W-1:0] mul_scalar,
  output logic [MAT_W-1:0]  mul_matrix,
  input  logic [MAT_W-1:0]  mul_result,
  input  logic              mul_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic [MAT_W-1:0]  rsp_matrix,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  err_count
);

  state_t     state, state_next;
  logic       ptr;
  logic       advance;
  logic [1:0] grant;
  cmd_t       cmd_sel;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign advance = (state == IDLE) && !reset;

  rr_arbiter2 u_arb (
    .req     ({req1_valid, req0_valid}),
    .advance (advance),
    .ptr     (ptr),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    cmd_sel = '{m: req0_m, n: req0_n, scalar: req0_scalar, matrix: req0_matrix};
    if (grant[1]) cmd_sel = '{m: req1_m, n: req1_n, scalar: req1_scalar, matrix: req1_matrix};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|grant) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand, response and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= 1'b0;
      busy       <= 1'b0;
      mul_m      <= '0;
      mul_n      <= '0;
      mul_scalar <= '0;
      mul_matrix <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_matrix <= '0;
      op_count   <= '0;
      err_count  <= '0;
    end else begin
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (|grant) begin
            mul_m      <= cmd_sel.m;
            mul_n      <= cmd_sel.n;
            mul_scalar <= cmd_sel.scalar;
            mul_matrix <= cmd_sel.matrix;
            rsp_id     <= grant[1];
            ptr        <= ~grant[1];
          end
        end
        ISSUE: begin
          rsp_matrix <= mul_result;
          rsp_err    <= ~mul_valid;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
            if (rsp_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mul_scheduler.sv
// Bench for scalar_mul_scheduler: directed table, corner sequences and a
// randomized phase checked by a queue-based reference model.
module tb_scalar_mul_scheduler;
  import calc_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic [DIM_W-1:0]  req0_m, req0_n, req1_m, req1_n;
  logic [SCAL_W-1:0] req0_scalar, req1_scalar;
  logic [MAT_W-1:0]  req0_matrix, req1_matrix;
  logic              req0_ready, req1_ready;
  logic [DIM_W-1:0]  mul_m, mul_n;
  logic [SCAL_W-1:0] mul_scalar;
  logic [MAT_W-1:0]  mul_matrix, mul_result;
  logic              mul_valid;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [MAT_W-1:0]  rsp_matrix;
  logic              busy;
  logic [CNT_W-1:0]  op_count, err_count;

  always #5 clk = ~clk;

  scalar_mul_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_m(req0_m), .req0_n(req0_n),
    .req0_scalar(req0_scalar), .req0_matrix(req0_matrix), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_m(req1_m), .req1_n(req1_n),
    .req1_scalar(req1_scalar), .req1_matrix(req1_matrix), .req1_ready(req1_ready),
    .mul_m(mul_m), .mul_n(mul_n), .mul_scalar(mul_scalar), .mul_matrix(mul_matrix),
    .mul_result(mul_result), .mul_valid(mul_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_matrix(rsp_matrix), .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m != 3'd0) && (int'(m) <= MAX_DIM) && (n != 3'd0) && (int'(n) <= MAX_DIM);
  endfunction

  // Product as the datapath defines it: wrap to 8 bits, zero outside m x n, all zero if dims invalid.
  function automatic logic [MAT_W-1:0] product(input logic [2:0] m, input logic [2:0] n,
                                               input logic [3:0] s, input logic [MAT_W-1:0] a);
    logic [MAT_W-1:0] r;
    r = '0;
    if (dims_ok(m, n)) begin
      for (int i = 0; i < int'(m); i++)
        for (int j = 0; j < int'(n); j++)
          r[(i*5+j)*8 +: 8] = 8'(int'(a[(i*5+j)*8 +: 8]) * int'(s));
    end
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] fill(input logic [7:0] v);
    logic [MAT_W-1:0] r;
    for (int k = 0; k < 25; k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] r;
    for (int k = 0; k < 25; k++) r[k*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  // External combinational datapath.
  always_comb begin
    mul_result = product(mul_m, mul_n, mul_scalar, mul_matrix);
    mul_valid  = dims_ok(mul_m, mul_n);
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic             id;
    logic             err;
    logic [MAT_W-1:0] mat;
    int               acc_cyc;
  } exp_t;

  exp_t             q[$];
  logic             grant_log[$];
  int               cyc = 0;
  int               exp_op = 0;
  int               exp_err = 0;
  bit               prev_hold = 0;
  logic             prev_id, prev_err;
  logic [MAT_W-1:0] prev_mat;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      check("ready_in_reset", {req1_ready, req0_ready}, 2'b00);
      q.delete();
      exp_op    = 0;
      exp_err   = 0;
      prev_hold = 0;
    end else begin
      check("op_count", op_count, (exp_op > 65535) ? 65535 : exp_op);
      check("err_count", err_count, (exp_err > 65535) ? 65535 : exp_err);
      if (req0_ready && req1_ready) check("ready_onehot", 2'b11, 2'b01);
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid))
        check("ready_without_valid", 1'b1, 1'b0);
      if (req0_ready || req1_ready) begin
        e.id      = req1_ready;
        e.err     = req1_ready ? !dims_ok(req1_m, req1_n) : !dims_ok(req0_m, req0_n);
        e.mat     = req1_ready ? product(req1_m, req1_n, req1_scalar, req1_matrix)
                               : product(req0_m, req0_n, req0_scalar, req0_matrix);
        e.acc_cyc = cyc;
        q.push_back(e);
        grant_log.push_back(e.id);
      end
      if (prev_hold) begin
        check("hold_valid", rsp_valid, 1'b1);
        check("hold_id", rsp_id, prev_id);
        check("hold_err", rsp_err, prev_err);
        check("hold_matrix", rsp_matrix, prev_mat);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("stale_response", 1'b1, 1'b0);
        end else begin
          if (!prev_hold) check("latency", cyc - q[0].acc_cyc, 2);
          check("rsp_id", rsp_id, q[0].id);
          check("rsp_err", rsp_err, q[0].err);
          check("rsp_matrix", rsp_matrix, q[0].mat);
          if (rsp_ready) begin
            if (q[0].err) exp_err++;
            exp_op++;
            void'(q.pop_front());
          end
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_id   = rsp_id;
      prev_err  = rsp_err;
      prev_mat  = rsp_matrix;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic id, input logic v, input logic [2:0] m, input logic [2:0] n,
                       input logic [3:0] s, input logic [MAT_W-1:0] mat);
    if (id) begin
      req1_valid = v; req1_m = m; req1_n = n; req1_scalar = s; req1_matrix = mat;
    end else begin
      req0_valid = v; req0_m = m; req0_n = n; req0_scalar = s; req0_matrix = mat;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic       id;
    logic [2:0] m, n;
    logic [3:0] s;
    logic [7:0] fill_v;
    logic       exp_err;
    logic [7:0] exp_e00;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [MAT_W-1:0] mat, m0, m1;
    vecs[0] = '{1'b0, 3'd2, 3'd3, 4'd3,  8'h05, 1'b0, 8'h0F};
    vecs[1] = '{1'b1, 3'd0, 3'd3, 4'd7,  8'h11, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 3'd6, 3'd2, 4'd2,  8'h11, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 3'd5, 3'd5, 4'd15, 8'h40, 1'b0, 8'hC0};
    vecs[4] = '{1'b1, 3'd5, 3'd5, 4'd1,  8'hFF, 1'b0, 8'hFF};
    vecs[5] = '{1'b0, 3'd1, 3'd1, 4'd0,  8'h33, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 3'd5, 3'd1, 4'd2,  8'h81, 1'b0, 8'h02};

    reset = 1'b1; rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 4'd0, '0);
    drive(1'b1, 1'b0, 3'd0, 3'd0, 4'd0, '0);
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("reset_req0_ready", req0_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_op_count", op_count, 0);
    check("reset_err_count", err_count, 0);
    check("reset_mul_m", mul_m, 0);
    check("reset_mul_matrix", mul_matrix, 0);
    check("reset_rsp_matrix", rsp_matrix, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; reset = 1'b0;

    // Table: single commands, one at a time.
    for (int k = 0; k < 7; k++) begin
      mat = fill(vecs[k].fill_v);
      @(posedge clk); #1;
      drive(vecs[k].id, 1'b1, vecs[k].m, vecs[k].n, vecs[k].s, mat);
      @(negedge clk);
      check("vec_ready", {req1_ready, req0_ready}, vecs[k].id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      drive(vecs[k].id, 1'b0, vecs[k].m, vecs[k].n, vecs[k].s, mat);
      @(negedge clk);
      check("vec_issue_rsp_valid", rsp_valid, 1'b0);
      check("vec_issue_busy", busy, 1'b1);
      @(negedge clk);
      check("vec_rsp_valid", rsp_valid, 1'b1);
      check("vec_rsp_id", rsp_id, vecs[k].id);
      check("vec_rsp_err", rsp_err, vecs[k].exp_err);
      check("vec_e00", rsp_matrix[7:0], vecs[k].exp_e00);
      check("vec_matrix", rsp_matrix, product(vecs[k].m, vecs[k].n, vecs[k].s, mat));
      @(negedge clk);
      check("vec_done_valid", rsp_valid, 1'b0);
      check("vec_done_busy", busy, 1'b0);
      check("vec_op_count", op_count, k + 1);
    end
    check("table_err_count", err_count, 2);

    // Contention: both requesters valid continuously after reset.
    do_reset();
    grant_log.delete();
    drive(1'b0, 1'b1, 3'd3, 3'd4, 4'd2, fill(8'h10));
    drive(1'b1, 1'b1, 3'd3, 3'd4, 4'd3, fill(8'h10));
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("contention_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("contention_g0", grant_log[0], 1'b0);
      check("contention_g1", grant_log[1], 1'b1);
      check("contention_g2", grant_log[2], 1'b0);
      check("contention_g3", grant_log[3], 1'b1);
    end

    // Backpressure: response held 5 cycles while req0 keeps requesting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd2, 3'd2, 4'd5, rand_mat());
    @(negedge clk);
    check("bp_accept", req0_ready, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_req0_ready_low", req0_ready, 1'b0);
    end
    check("bp_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_ready_low", req0_ready, 1'b0);
    @(negedge clk);
    check("bp_next_accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ISSUE.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 3'd2, 3'd2, 4'd3, fill(8'h07));
    @(negedge clk);
    check("rst_issue_accept", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_issue_rsp_valid", rsp_valid, 1'b0);
    check("rst_issue_busy", busy, 1'b0);
    check("rst_issue_op_count", op_count, 0);
    repeat (3) @(negedge clk);
    check("rst_issue_no_stale", rsp_valid, 1'b0);

    // Reset during RESP, after a grant to requester 0.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd1, 3'd1, 4'd9, fill(8'h03));
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_pending", rsp_valid, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_resp_rsp_valid", rsp_valid, 1'b0);
    check("rst_resp_busy", busy, 1'b0);
    check("rst_resp_counts", {op_count, err_count}, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'd1, 3'd2, 4'd4, fill(8'h02));
    drive(1'b1, 1'b1, 3'd1, 3'd2, 4'd5, fill(8'h02));
    @(negedge clk);
    check("rst_priority", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_after_op_count", op_count, 1);

    // Randomized traffic with occasional resets and backpressure.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      m0 = rand_mat();
      m1 = rand_mat();
      drive(1'b0, ($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 4'($urandom), m0);
      drive(1'b1, ($urandom_range(0, 2) != 0), 3'($urandom), 3'($urandom), 4'($urandom), m1);
      rsp_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
    check("drain_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
